data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_AW, default 11, the word address width of the data RAM.
REQ-002 SHALL have parameter DW, default 32, the data width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have requester ports for p in {cpu, dbg}, all inputs:
- p_req (1): request.
- p_we (1): write enable.
- p_addr (32): virtual byte address.
- p_wdata (DW): write data.
- p_be (4): byte enables.
REQ-006 SHALL have per-requester outputs:
- p_gnt (1): access accepted.
- p_rvalid (1): response valid.
- p_rdata (DW): read data.
- p_inv_addr (1): address outside both regions.
REQ-007 SHALL have RAM-side ports:
- mem_en, output, 1 bit.
- mem_we, output, 4 bits.
- mem_addr, output, MEM_AW bits.
- mem_wdata, output, DW bits.
- mem_rdata, input, DW bits: synchronous read, 1-cycle latency.

Function
REQ-008 SHALL run an FSM with states IDLE, ACCESS and RESP; each non-IDLE state SHALL last exactly one cycle.
REQ-009 In IDLE with any p_req=1, SHALL pick the winner, register its we/addr/wdata/be and decoded address, and go to ACCESS.
REQ-010 In ACCESS, SHALL pulse the winner's p_gnt for one cycle. For a valid address it SHALL drive mem_en=1, mem_addr=decoded, mem_we=be when we=1 (else 0) and mem_wdata. It then goes to RESP.
REQ-011 In RESP, SHALL pulse the winner's p_rvalid for one cycle, then return to IDLE.
- Read: p_rdata = mem_rdata.
- Write: p_rdata = 0.
REQ-012 Latency: p_req sampled at cycle 0, p_gnt at cycle 1, p_rvalid at cycle 2. Throughput is one access per 3 cycles.
REQ-013 A requester SHALL hold p_req and its request fields stable until it sees p_gnt. A request is not re-sampled while the FSM is outside IDLE.
REQ-014 Decode: 0x10010000–0x10010FFF → word (addr−0x10010000)>>2, range 0–1023. 0x7FFFF000–0x7FFFFFFF → 1024+((addr−0x7FFFF000)>>2). addr[1:0] is ignored.
REQ-015 Any other address SHALL keep mem_en=0 in ACCESS, still pulse p_gnt, and in RESP drive p_rvalid=1, p_inv_addr=1, p_rdata=0.
REQ-016 p_inv_addr SHALL be asserted only in the RESP cycle of the owning requester.
REQ-017 Region boundaries: 0x10010FFC and 0x7FFFFFFC are valid. 0x10011000 and 0x7FFFEFFC are invalid.
REQ-018 The non-winning requester SHALL see p_gnt=0 and p_rvalid=0 and stay pending. It is served on the next pass through IDLE.
REQ-019 Outputs to the idle requester and unused RAM fields SHALL be 0.

Reset
REQ-020 While rst_n=0:
- FSM state = IDLE.
- RR pointer = cpu.
- All outputs = 0.
REQ-021 Reset during ACCESS or RESP SHALL abandon the access: no p_rvalid is issued afterwards, and the write already issued (if any) is not retracted.
REQ-022 Reset deassertion SHALL take effect at the next rising clk edge. The first sample is in IDLE.

Configuration
REQ-023 Macro DATA_MEM_ARB_RR_EN selects the arbitration scheme on simultaneous requests.
- Defined: round-robin. A 1-bit pointer holds the last winner; the other requester wins next. The pointer updates only on IDLE→ACCESS.
- Undefined: fixed priority, cpu beats dbg.
- In both builds a lone requester always wins.

Structure
REQ-024 Package mips32soc_mem_pkg SHALL hold:
- The region base and limit constants.
- The FSM state enum.
- The requester-id typedef.
REQ-025 Address decode SHALL be the combinational sub-module data_mem_decoder (addr in; word index and invalid flag out). It is instantiated once, on the selected request address.

Verification
REQ-026 cpu read at 0x10010004, RAM word 1 = 0xDEADBEEF → cpu_gnt at cycle 1, cpu_rvalid at cycle 2, cpu_rdata=0xDEADBEEF.
REQ-027 dbg write to 0x7FFFFFFC, wdata 0x12345678, be=0xF → mem_addr=2047, mem_we=0xF in ACCESS; dbg_rvalid=1, dbg_rdata=0 in RESP.
REQ-028 cpu read at 0x10011000 → mem_en stays 0; cpu_rvalid=1, cpu_inv_addr=1, cpu_rdata=0.
REQ-029 cpu and dbg request together, three times:
- With DATA_MEM_ARB_RR_EN: grant order is cpu, dbg, cpu.
- Without it: grant order is cpu, cpu, cpu while cpu_req stays high.
REQ-030 rst_n dropped during the RESP cycle of a read → all outputs 0 immediately; no rvalid after release; the FSM resumes in IDLE.

Source files
------------

// File: rtl/mips32soc_mem_pkg.sv
// ----------------------------------------------------------------------------
// mips32soc_mem_pkg
// Purpose : Shared definitions for the data-RAM arbiter. It holds the address
//           map of the two data regions, the arbiter FSM state type and the
//           requester identifier type.
// Contents:
//   LO_BASE / LO_LIMIT  - low data region, byte addresses
//   HI_BASE / HI_LIMIT  - high (stack) region, byte addresses
//   HI_WORD_BASE        - first RAM word index of the high region
//   arb_state_e         - IDLE / ACCESS / RESP
//   req_id_e            - cpu / dbg requester identifier
// ----------------------------------------------------------------------------
package mips32soc_mem_pkg;

    localparam logic [31:0] LO_BASE      = 32'h1001_0000;
    localparam logic [31:0] LO_LIMIT     = 32'h1001_0FFF;
    localparam logic [31:0] HI_BASE      = 32'h7FFF_F000;
    localparam logic [31:0] HI_LIMIT     = 32'h7FFF_FFFF;
    localparam logic [31:0] HI_WORD_BASE = 32'd1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_e;

endpackage

// File: rtl/data_mem_decoder.sv
// ----------------------------------------------------------------------------
// data_mem_decoder
// Purpose : Combinational translation of a virtual byte address into a RAM
//           word index. The low region maps to words 0..1023 and the high
//           region to words starting at 1024. Byte-offset bits [1:0] are
//           ignored. Any address outside both regions is flagged invalid and
//           yields word index 0.
// Ports   :
//   i_addr    [31:0]       - virtual byte address
//   o_word    [MEM_AW-1:0] - RAM word index
//   o_invalid              - address is in neither region
// ----------------------------------------------------------------------------
module data_mem_decoder
    import mips32soc_mem_pkg::*;
#(
    parameter int MEM_AW = 11
) (
    input  logic [31:0]       i_addr,
    output logic [MEM_AW-1:0] o_word,
    output logic              o_invalid
);

    logic        w_in_lo;
    logic        w_in_hi;
    logic [31:0] w_word32;

    assign w_in_lo = (i_addr >= LO_BASE) && (i_addr <= LO_LIMIT);
    assign w_in_hi = (i_addr >= HI_BASE) && (i_addr <= HI_LIMIT);

    always_comb begin
        w_word32 = 32'd0;
        if (w_in_lo) begin
            w_word32 = (i_addr - LO_BASE) >> 2;
        end else if (w_in_hi) begin
            w_word32 = HI_WORD_BASE + ((i_addr - HI_BASE) >> 2);
        end
    end

    // Region offsets never exceed 2048 words, so truncation is lossless for
    // the default RAM size.
    assign o_word    = MEM_AW'(w_word32);
    assign o_invalid = !(w_in_lo || w_in_hi);

endmodule

// File: rtl/data_mem_arbiter.sv
// ----------------------------------------------------------------------------
// data_mem_arbiter
// Purpose : Shares one synchronous-read data RAM between the cpu and the debug
//           requester. Each access runs IDLE -> ACCESS -> RESP, one cycle per
//           non-idle state: grant in ACCESS, response in RESP.
// Config  : `define DATA_MEM_ARB_RR_EN selects round-robin arbitration on
//           simultaneous requests; without it cpu has fixed priority.
// Ports   :
//   clk, rst_n                   - clock, asynchronous active-low reset
//   {cpu,dbg}_req/_we/_addr/_wdata/_be - request inputs (held until gnt)
//   {cpu,dbg}_gnt                - one-cycle grant in ACCESS
//   {cpu,dbg}_rvalid             - one-cycle response in RESP
//   {cpu,dbg}_rdata              - read data in RESP (0 for writes/invalid)
//   {cpu,dbg}_inv_addr           - address outside both regions, in RESP
//   mem_en/_we/_addr/_wdata      - RAM command, driven in ACCESS only
//   mem_rdata                    - RAM read data, one cycle after mem_en
// ----------------------------------------------------------------------------
module data_mem_arbiter
    import mips32soc_mem_pkg::*;
#(
    parameter int MEM_AW = 11,
    parameter int DW     = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DW-1:0]     cpu_wdata,
    input  logic [3:0]        cpu_be,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DW-1:0]     cpu_rdata,
    output logic              cpu_inv_addr,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [31:0]       dbg_addr,
    input  logic [DW-1:0]     dbg_wdata,
    input  logic [3:0]        dbg_be,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DW-1:0]     dbg_rdata,
    output logic              dbg_inv_addr,

    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);

    arb_state_e        r_state;
    req_id_e           r_owner;
    logic              r_we;
    logic              r_inv;

    logic              r_cpu_gnt;
    logic              r_dbg_gnt;
    logic              r_cpu_rvalid;
    logic              r_dbg_rvalid;
    logic              r_cpu_inv;
    logic              r_dbg_inv;

    logic              r_mem_en;
    logic [3:0]        r_mem_we;
    logic [MEM_AW-1:0] r_mem_addr;
    logic [DW-1:0]     r_mem_wdata;

    logic              w_any_req;
    req_id_e           w_sel;
    logic              w_sel_we;
    logic [31:0]       w_sel_addr;
    logic [DW-1:0]     w_sel_wdata;
    logic [3:0]        w_sel_be;
    logic [MEM_AW-1:0] w_dec_word;
    logic              w_dec_inv;
    logic [DW-1:0]     w_resp_rdata;

    assign w_any_req = cpu_req || dbg_req;

    // ------------------------------------------------------------------------
    // Winner selection. Only consulted while the FSM sits in IDLE.
    // ------------------------------------------------------------------------
`ifdef DATA_MEM_ARB_RR_EN
    req_id_e r_last;  // last winner; the other side wins the next tie

    always_comb begin
        w_sel = REQ_CPU;
        if (cpu_req && dbg_req) begin
            w_sel = (r_last == REQ_CPU) ? REQ_DBG : REQ_CPU;
        end else if (dbg_req) begin
            w_sel = REQ_DBG;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= REQ_CPU;
        end else if (r_state == ST_IDLE && w_any_req) begin
            r_last <= w_sel;
        end
    end
`else
    always_comb begin
        w_sel = REQ_CPU;
        if (dbg_req && !cpu_req) begin
            w_sel = REQ_DBG;
        end
    end
`endif

    assign w_sel_we    = (w_sel == REQ_DBG) ? dbg_we    : cpu_we;
    assign w_sel_addr  = (w_sel == REQ_DBG) ? dbg_addr  : cpu_addr;
    assign w_sel_wdata = (w_sel == REQ_DBG) ? dbg_wdata : cpu_wdata;
    assign w_sel_be    = (w_sel == REQ_DBG) ? dbg_be    : cpu_be;

    data_mem_decoder #(
        .MEM_AW (MEM_AW)
    ) u_decoder (
        .i_addr    (w_sel_addr),
        .o_word    (w_dec_word),
        .o_invalid (w_dec_inv)
    );

    // ------------------------------------------------------------------------
    // Access FSM. The RAM command is loaded on the IDLE->ACCESS edge so that
    // it is present on the mem_* outputs throughout the ACCESS cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= REQ_CPU;
            r_we         <= 1'b0;
            r_inv        <= 1'b0;
            r_cpu_gnt    <= 1'b0;
            r_dbg_gnt    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_cpu_inv    <= 1'b0;
            r_dbg_inv    <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 4'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state     <= ST_ACCESS;
                        r_owner     <= w_sel;
                        r_we        <= w_sel_we;
                        r_inv       <= w_dec_inv;
                        r_cpu_gnt   <= (w_sel == REQ_CPU);
                        r_dbg_gnt   <= (w_sel == REQ_DBG);
                        r_mem_en    <= !w_dec_inv;
                        r_mem_addr  <= w_dec_inv ? '0 : w_dec_word;
                        r_mem_we    <= (!w_dec_inv && w_sel_we) ? w_sel_be : 4'b0;
                        r_mem_wdata <= (!w_dec_inv && w_sel_we) ? w_sel_wdata : '0;
                    end
                end
                ST_ACCESS: begin
                    r_state      <= ST_RESP;
                    r_cpu_gnt    <= 1'b0;
                    r_dbg_gnt    <= 1'b0;
                    r_mem_en     <= 1'b0;
                    r_mem_we     <= 4'b0;
                    r_mem_addr   <= '0;
                    r_mem_wdata  <= '0;
                    r_cpu_rvalid <= (r_owner == REQ_CPU);
                    r_dbg_rvalid <= (r_owner == REQ_DBG);
                    r_cpu_inv    <= (r_owner == REQ_CPU) && r_inv;
                    r_dbg_inv    <= (r_owner == REQ_DBG) && r_inv;
                end
                ST_RESP: begin
                    r_state      <= ST_IDLE;
                    r_cpu_rvalid <= 1'b0;
                    r_dbg_rvalid <= 1'b0;
                    r_cpu_inv    <= 1'b0;
                    r_dbg_inv    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM data arrives during RESP, so read data is steered straight through
    // rather than registered; gating on r_state also forces it to 0 the
    // moment reset asserts.
    assign w_resp_rdata = (r_state == ST_RESP && !r_we && !r_inv) ? mem_rdata : '0;

    assign cpu_gnt      = r_cpu_gnt;
    assign cpu_rvalid   = r_cpu_rvalid;
    assign cpu_inv_addr = r_cpu_inv;
    assign cpu_rdata    = (r_owner == REQ_CPU) ? w_resp_rdata : '0;

    assign dbg_gnt      = r_dbg_gnt;
    assign dbg_rvalid   = r_dbg_rvalid;
    assign dbg_inv_addr = r_dbg_inv;
    assign dbg_rdata    = (r_owner == REQ_DBG) ? w_resp_rdata : '0;

    assign mem_en       = r_mem_en;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_data_mem_arbiter
// Directed bench for data_mem_arbiter with a byte-enabled, registered-read RAM
// model. Expected values are hand-computed per vector. Build with
// +define+DATA_MEM_ARB_RR_EN to exercise the round-robin build.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_mem_arbiter;

    logic        clk;
    logic        rst_n;

    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [3:0]  cpu_be, dbg_be;
    logic        cpu_gnt, cpu_rvalid, cpu_inv_addr;
    logic        dbg_gnt, dbg_rvalid, dbg_inv_addr;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_total = 0;
    int n_bad   = 0;

    data_mem_arbiter #(
        .MEM_AW (11),
        .DW     (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_be       (cpu_be),
        .cpu_gnt      (cpu_gnt),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_rdata    (cpu_rdata),
        .cpu_inv_addr (cpu_inv_addr),
        .dbg_req      (dbg_req),
        .dbg_we       (dbg_we),
        .dbg_addr     (dbg_addr),
        .dbg_wdata    (dbg_wdata),
        .dbg_be       (dbg_be),
        .dbg_gnt      (dbg_gnt),
        .dbg_rvalid   (dbg_rvalid),
        .dbg_rdata    (dbg_rdata),
        .dbg_inv_addr (dbg_inv_addr),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: byte-enabled write, registered read.
    logic [31:0] ram [0:2047];
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= ram[mem_addr];
        end
    end

    logic any_out;
    assign any_out = |{cpu_gnt, cpu_rvalid, cpu_rdata, cpu_inv_addr,
                       dbg_gnt, dbg_rvalid, dbg_rdata, dbg_inv_addr,
                       mem_en, mem_we, mem_addr, mem_wdata};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete access by a single requester: request in cycle 0,
    // grant/RAM command in cycle 1, response in cycle 2, idle in cycle 3.
    task automatic txn(input string name, input bit is_dbg, input logic we,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input bit exp_ok,
                       input logic [10:0] exp_word, input logic [31:0] exp_rdata);
        if (is_dbg) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd; dbg_be = be;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_be = be;
        end
        step();
        chk({name, ":gnt"},       is_dbg ? dbg_gnt : cpu_gnt, 1);
        chk({name, ":other_gnt"}, is_dbg ? cpu_gnt : dbg_gnt, 0);
        chk({name, ":mem_en"},    mem_en, exp_ok);
        chk({name, ":mem_addr"},  mem_addr, exp_ok ? exp_word : 11'd0);
        chk({name, ":mem_we"},    mem_we, (exp_ok && we) ? be : 4'd0);
        chk({name, ":mem_wdata"}, mem_wdata, (exp_ok && we) ? wd : 32'd0);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        step();
        chk({name, ":rvalid"}, is_dbg ? dbg_rvalid : cpu_rvalid, 1);
        chk({name, ":rdata"},  is_dbg ? dbg_rdata  : cpu_rdata, exp_rdata);
        chk({name, ":inv"},    is_dbg ? dbg_inv_addr : cpu_inv_addr, !exp_ok);
        chk({name, ":other_resp"},
            is_dbg ? (cpu_rvalid | cpu_inv_addr | (|cpu_rdata))
                   : (dbg_rvalid | dbg_inv_addr | (|dbg_rdata)), 0);
        chk({name, ":mem_idle_in_resp"}, mem_en, 0);
        $display("txn %s: %s %s addr=0x%08h rdata=0x%08h inv=%0d", name,
                 is_dbg ? "dbg" : "cpu", we ? "wr" : "rd", addr,
                 is_dbg ? dbg_rdata : cpu_rdata,
                 is_dbg ? dbg_inv_addr : cpu_inv_addr);
        step();
        chk({name, ":idle_after"}, cpu_rvalid | dbg_rvalid | cpu_gnt | dbg_gnt, 0);
    endtask

    logic [2:0] exp_cpu_order;
    int         rv_after_rst;

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 32'd0;
        ram[1]    = 32'hDEADBEEF;
        mem_rdata = 32'd0;
        rst_n   = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_be = 4'd0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'd0; dbg_wdata = 32'd0; dbg_be = 4'd0;
`ifdef DATA_MEM_ARB_RR_EN
        exp_cpu_order = 3'b101;
`else
        exp_cpu_order = 3'b111;
`endif

        // Reset state
        step();
        chk("reset:outputs", any_out, 0);
        cpu_req = 1'b1;  // must be ignored while held in reset
        step();
        chk("reset:no_gnt", cpu_gnt, 0);
        cpu_req = 1'b0;
        rst_n = 1'b1;

        // First request right after reset release is served from IDLE
        txn("cpu_rd_word1", 1'b0, 1'b0, 32'h1001_0004, 32'd0, 4'h0, 1'b1, 11'd1, 32'hDEADBEEF);
        txn("cpu_wr_lo_top", 1'b0, 1'b1, 32'h1001_0FFC, 32'hCAFEF00D, 4'hC, 1'b1, 11'd1023, 32'd0);
        txn("cpu_rd_lo_past", 1'b0, 1'b0, 32'h1001_1000, 32'd0, 4'h0, 1'b0, 11'd0, 32'd0);
        txn("dbg_rd_hi_below", 1'b1, 1'b0, 32'h7FFF_EFFC, 32'd0, 4'h0, 1'b0, 11'd0, 32'd0);
        txn("dbg_wr_inv_nowrite", 1'b1, 1'b1, 32'h0000_0040, 32'h1111_1111, 4'hF, 1'b0, 11'd0, 32'd0);

        // Reset during RESP of a read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1001_0004; cpu_be = 4'h0;
        step();
        chk("rst_resp:gnt", cpu_gnt, 1);
        cpu_req = 1'b0;
        step();
        chk("rst_resp:in_resp", cpu_rvalid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_resp:outputs_zero", any_out, 0);
        step();
        step();
        rst_n = 1'b1;
        rv_after_rst = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (cpu_rvalid || dbg_rvalid || cpu_gnt || dbg_gnt) rv_after_rst++;
        end
        chk("rst_resp:no_rvalid_after", rv_after_rst, 0);
        $display("txn reset_in_resp: released, activity cycles=%0d", rv_after_rst);

        // High region, boundary and byte-enable checks; the last one is dbg
        txn("dbg_wr_hi_top", 1'b1, 1'b1, 32'h7FFF_FFFC, 32'h12345678, 4'hF, 1'b1, 11'd2047, 32'd0);
        txn("cpu_rd_hi_top", 1'b0, 1'b0, 32'h7FFF_FFFC, 32'd0, 4'h0, 1'b1, 11'd2047, 32'h12345678);
        txn("dbg_rd_hi_base", 1'b1, 1'b0, 32'h7FFF_F000, 32'd0, 4'h0, 1'b1, 11'd1024, 32'd0);
        txn("dbg_rd_lo_top_b1", 1'b1, 1'b0, 32'h1001_0FFD, 32'd0, 4'h0, 1'b1, 11'd1023, 32'hCAFE0000);
        txn("cpu_rd_after_inv_wr", 1'b0, 1'b0, 32'h1001_0000, 32'd0, 4'h0, 1'b1, 11'd0, 32'd0);
        txn("dbg_rd_word1", 1'b1, 1'b0, 32'h1001_0004, 32'd0, 4'h0, 1'b1, 11'd1, 32'hDEADBEEF);

        // Simultaneous requests held high for three passes
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1001_0004; cpu_be = 4'h0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h7FFF_FFFC; dbg_be = 4'h0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("contend%0d:cpu_gnt", k), cpu_gnt, exp_cpu_order[k]);
            chk($sformatf("contend%0d:dbg_gnt", k), dbg_gnt, !exp_cpu_order[k]);
            step();
            chk($sformatf("contend%0d:cpu_rvalid", k), cpu_rvalid, exp_cpu_order[k]);
            chk($sformatf("contend%0d:dbg_rvalid", k), dbg_rvalid, !exp_cpu_order[k]);
            chk($sformatf("contend%0d:rdata", k),
                exp_cpu_order[k] ? cpu_rdata : dbg_rdata,
                exp_cpu_order[k] ? 32'hDEADBEEF : 32'h12345678);
            $display("txn contend%0d: winner=%s", k, cpu_rvalid ? "cpu" : "dbg");
            step();
        end
        // The pending dbg request is served once cpu lets go
        cpu_req = 1'b0;
        step();
        chk("drain:dbg_gnt", dbg_gnt, 1);
        chk("drain:cpu_gnt", cpu_gnt, 0);
        dbg_req = 1'b0;
        step();
        chk("drain:dbg_rvalid", dbg_rvalid, 1);
        chk("drain:dbg_rdata", dbg_rdata, 32'h12345678);
        $display("txn drain: dbg rdata=0x%08h", dbg_rdata);
        step();
        chk("drain:idle", any_out, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
